// File: rtl/pipe_hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_ctrl_pkg
//  Brief    : Shared types and constants for the WiscSP13 pipeline
//             stall/flush controller: state encoding, register address
//             width, default timing parameters and the control bundle.
//  Revision : 1.0  initial release
// ============================================================================
package pipe_ctrl_pkg;

    localparam int c_REG_ADDR_W       = 3;
    localparam int c_DEF_DRAIN_CYCLES = 2;
    localparam int c_DEF_MAX_WAIT     = 15;
    localparam int c_DEF_CNT_W        = 16;

    // Controller state encoding (fixed, visible in waveforms and debug)
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2,
        HALTED   = 2'd3
    } state_e;

    // One bundle of pipeline register controls, MSB first as listed
    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
    } ctrl_t;

    // Everything frozen: no bank loads, no bubbles
    localparam ctrl_t c_CTRL_FREEZE   = 8'b00000_000;
    // Normal advance
    localparam ctrl_t c_CTRL_RUN      = 8'b11111_000;
    // Squash the three younger stages, PC loads the redirect target
    localparam ctrl_t c_CTRL_REDIRECT = 8'b11111_111;
    // Hold PC and IF/ID, drop one bubble into ID/EX; a bubble is a load
    // so the ID/EX bank stays enabled
    localparam ctrl_t c_CTRL_LOAD_USE = 8'b00111_010;
    // Halt drain: PC frozen, younger stages filled with bubbles, older
    // stages keep retiring
    localparam ctrl_t c_CTRL_DRAIN    = 8'b01111_111;

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl_if
//  Brief    : Hazard information from the pipeline stages and the stall /
//             flush controls returned to them. The pipeline side is the
//             master, the controller is the slave.
//  Revision : 1.0  initial release
// ============================================================================
interface pipe_hazard_ctrl_if;
    import pipe_ctrl_pkg::*;

    logic [c_REG_ADDR_W-1:0] ID_rs_addr;
    logic [c_REG_ADDR_W-1:0] ID_rt_addr;
    logic                    ID_rs_used;
    logic                    ID_rt_used;
    logic [c_REG_ADDR_W-1:0] EX_rd_addr;
    logic                    EX_reg_write;
    logic                    EX_mem_read;
    logic                    MEM_redirect;
    logic                    MEM_halt;
    logic                    dmem_busy;

    logic                    pc_en;
    logic                    if_id_en;
    logic                    id_ex_en;
    logic                    ex_mem_en;
    logic                    mem_wb_en;
    logic                    if_id_flush;
    logic                    id_ex_flush;
    logic                    ex_mem_flush;
    logic                    halted;
    logic                    err;

    modport master (
        output ID_rs_addr, ID_rt_addr, ID_rs_used, ID_rt_used,
        output EX_rd_addr, EX_reg_write, EX_mem_read,
        output MEM_redirect, MEM_halt, dmem_busy,
        input  pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        input  if_id_flush, id_ex_flush, ex_mem_flush, halted, err
    );

    modport slave (
        input  ID_rs_addr, ID_rt_addr, ID_rs_used, ID_rt_used,
        input  EX_rd_addr, EX_reg_write, EX_mem_read,
        input  MEM_redirect, MEM_halt, dmem_busy,
        output pc_en, if_id_en, id_ex_en, ex_mem_en, mem_wb_en,
        output if_id_flush, id_ex_flush, ex_mem_flush, halted, err
    );

endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_load_use_det.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_load_use_det
//  Brief    : Purely combinational load-use compare between the source
//             registers of the ID instruction and the destination of a
//             load in EX. R0 is an ordinary register and is compared.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_load_use_det
    import pipe_ctrl_pkg::*;
(
    input  wire logic [c_REG_ADDR_W-1:0] i_rs_addr,
    input  wire logic [c_REG_ADDR_W-1:0] i_rt_addr,
    input  wire logic                    i_rs_used,
    input  wire logic                    i_rt_used,
    input  wire logic [c_REG_ADDR_W-1:0] i_ex_rd_addr,
    input  wire logic                    i_ex_reg_write,
    input  wire logic                    i_ex_mem_read,
    output      logic                    o_load_use
);

    logic w_rs_hit;
    logic w_rt_hit;

    // A source only conflicts when the ID instruction actually reads it
    always_comb begin
        w_rs_hit   = i_rs_used && (i_rs_addr == i_ex_rd_addr);
        w_rt_hit   = i_rt_used && (i_rt_addr == i_ex_rd_addr);
        o_load_use = i_ex_mem_read && i_ex_reg_write && (w_rs_hit || w_rt_hit);
    end

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pipe_hazard_ctrl
//  Brief    : Central stall/flush controller for the 5-stage WiscSP13 core.
//             Priority: data-memory wait, halt drain, MEM redirect,
//             load-use. Timed-out memory waits set a sticky error and
//             freeze the core.
//  Options  : PIPE_HAZARD_STALL_CNT_EN adds a saturating stall_cnt output
//             counting PC-frozen cycles in RUN / MEM_WAIT.
//  Revision : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int DRAIN_CYCLES = c_DEF_DRAIN_CYCLES,
    parameter int MAX_WAIT     = c_DEF_MAX_WAIT
`ifdef PIPE_HAZARD_STALL_CNT_EN
    ,
    parameter int CNT_W        = c_DEF_CNT_W
`endif
)(
    input  wire logic               clk,
    input  wire logic               rst,
    pipe_hazard_ctrl_if.slave       bus
`ifdef PIPE_HAZARD_STALL_CNT_EN
    ,
    output      logic [CNT_W-1:0]   stall_cnt
`endif
);

    localparam logic [7:0] c_WAIT_LAST  = 8'(MAX_WAIT);
    localparam logic [7:0] c_DRAIN_LAST = 8'(DRAIN_CYCLES);

    state_e     r_state_q;
    state_e     w_state_d;
    logic [7:0] r_wait_cnt_q;
    logic [7:0] w_wait_cnt_d;
    logic [7:0] r_drain_cnt_q;
    logic [7:0] w_drain_cnt_d;
    logic       r_halted_q;
    logic       w_halted_d;
    logic       r_err_q;
    logic       w_err_d;
    ctrl_t      w_ctrl;
    logic       w_load_use;

    pipe_load_use_det u_load_use_det (
        .i_rs_addr      (bus.ID_rs_addr),
        .i_rt_addr      (bus.ID_rt_addr),
        .i_rs_used      (bus.ID_rs_used),
        .i_rt_used      (bus.ID_rt_used),
        .i_ex_rd_addr   (bus.EX_rd_addr),
        .i_ex_reg_write (bus.EX_reg_write),
        .i_ex_mem_read  (bus.EX_mem_read),
        .o_load_use     (w_load_use)
    );

    // Next-state, counter and control decode; defaults freeze everything
    always_comb begin
        w_state_d     = r_state_q;
        w_wait_cnt_d  = r_wait_cnt_q;
        w_drain_cnt_d = r_drain_cnt_q;
        w_err_d       = r_err_q;
        w_ctrl        = c_CTRL_FREEZE;

        case (r_state_q)
            RUN: begin
                if (bus.dmem_busy) begin
                    w_state_d    = MEM_WAIT;
                    w_wait_cnt_d = 8'd1;
                end else if (bus.MEM_halt) begin
                    w_ctrl        = c_CTRL_DRAIN;
                    w_state_d     = DRAIN;
                    w_drain_cnt_d = 8'd1;
                end else if (bus.MEM_redirect) begin
                    // The squash already removes the dependent instruction,
                    // so a coincident load-use needs no stall
                    w_ctrl = c_CTRL_REDIRECT;
                end else if (w_load_use) begin
                    w_ctrl = c_CTRL_LOAD_USE;
                end else begin
                    w_ctrl = c_CTRL_RUN;
                end
            end

            MEM_WAIT: begin
                // The completion cycle is still frozen; RUN resumes next
                if (!bus.dmem_busy) begin
                    w_state_d    = RUN;
                    w_wait_cnt_d = 8'd0;
                end else if (r_wait_cnt_q == c_WAIT_LAST) begin
                    w_err_d   = 1'b1;
                    w_state_d = HALTED;
                end else begin
                    w_wait_cnt_d = r_wait_cnt_q + 8'd1;
                end
            end

            DRAIN: begin
                // A busy memory freezes the drain in place (no bubbles
                // either) and the cycle does not count toward the drain
                if (!bus.dmem_busy) begin
                    w_ctrl = c_CTRL_DRAIN;
                    if (r_drain_cnt_q >= c_DRAIN_LAST) begin
                        w_state_d = HALTED;
                    end else begin
                        w_drain_cnt_d = r_drain_cnt_q + 8'd1;
                    end
                end
            end

            HALTED: begin
                w_ctrl = c_CTRL_FREEZE;
            end

            default: begin
                w_state_d = RUN;
            end
        endcase

        w_halted_d = (w_state_d == HALTED);
    end

    // Controller state registers, asynchronously cleared
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state_q     <= RUN;
            r_wait_cnt_q  <= 8'd0;
            r_drain_cnt_q <= 8'd0;
            r_halted_q    <= 1'b0;
            r_err_q       <= 1'b0;
        end else begin
            r_state_q     <= w_state_d;
            r_wait_cnt_q  <= w_wait_cnt_d;
            r_drain_cnt_q <= w_drain_cnt_d;
            r_halted_q    <= w_halted_d;
            r_err_q       <= w_err_d;
        end
    end

    // Controls are forced inactive for as long as reset is held
    assign bus.pc_en        = rst & w_ctrl.pc_en;
    assign bus.if_id_en     = rst & w_ctrl.if_id_en;
    assign bus.id_ex_en     = rst & w_ctrl.id_ex_en;
    assign bus.ex_mem_en    = rst & w_ctrl.ex_mem_en;
    assign bus.mem_wb_en    = rst & w_ctrl.mem_wb_en;
    assign bus.if_id_flush  = rst & w_ctrl.if_id_flush;
    assign bus.id_ex_flush  = rst & w_ctrl.id_ex_flush;
    assign bus.ex_mem_flush = rst & w_ctrl.ex_mem_flush;
    assign bus.halted       = r_halted_q;
    assign bus.err          = r_err_q;

`ifdef PIPE_HAZARD_STALL_CNT_EN
    logic [CNT_W-1:0] r_stall_cnt_q;
    logic [CNT_W-1:0] w_stall_cnt_d;

    // Count PC-frozen cycles due to hazards and memory waits, saturating
    always_comb begin
        w_stall_cnt_d = r_stall_cnt_q;
        if (((r_state_q == RUN) || (r_state_q == MEM_WAIT)) &&
            !w_ctrl.pc_en && !(&r_stall_cnt_q)) begin
            w_stall_cnt_d = r_stall_cnt_q + CNT_W'(1);
        end
    end

    // Stall counter register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt_q <= '0;
        end else begin
            r_stall_cnt_q <= w_stall_cnt_d;
        end
    end

    assign stall_cnt = r_stall_cnt_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pipe_hazard_ctrl
//  Brief    : Self-checking bench for pipe_hazard_ctrl: directed vector
//             table, hand-written timeout / reset sequences and random
//             stimulus against a behavioural model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

    localparam int DRAIN_CYCLES = 2;
    localparam int MAX_WAIT     = 15;
    localparam int CNT_W        = 16;

    // Expected output word: {pc,ifid,idex,exmem,memwb en, ifid,idex,exmem flush, halted, err}
    localparam logic [9:0] P_RUN = 10'b11111_000_00;
    localparam logic [9:0] P_LU  = 10'b00111_010_00;
    localparam logic [9:0] P_RDR = 10'b11111_111_00;
    localparam logic [9:0] P_DRN = 10'b01111_111_00;
    localparam logic [9:0] P_FRZ = 10'b00000_000_00;
    localparam logic [9:0] P_HLT = 10'b00000_000_10;
    localparam logic [9:0] P_ERR = 10'b00000_000_11;

    typedef struct packed {
        logic [2:0] rs;
        logic [2:0] rt;
        logic       rs_u;
        logic       rt_u;
        logic [2:0] rd;
        logic       rw;
        logic       mr;
        logic       redir;
        logic       halt;
        logic       busy;
    } in_t;

    typedef struct {
        in_t        i;
        logic [9:0] exp;
        string      name;
    } vec_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    pipe_hazard_ctrl_if bus ();

`ifdef PIPE_HAZARD_STALL_CNT_EN
    logic [CNT_W-1:0] stall_cnt;
    pipe_hazard_ctrl #(.DRAIN_CYCLES(DRAIN_CYCLES), .MAX_WAIT(MAX_WAIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst_n), .bus(bus), .stall_cnt(stall_cnt));
`else
    pipe_hazard_ctrl #(.DRAIN_CYCLES(DRAIN_CYCLES), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst_n), .bus(bus));
`endif

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- behavioural model ----------------
    bit m_halted, m_err, m_in_wait, m_draining;
    int m_streak;   // consecutive busy cycles of the current memory access
    int m_drained;  // drain cycles that advanced the older stages
    int m_stall;

    task automatic model_reset();
        m_halted = 0; m_err = 0; m_in_wait = 0; m_draining = 0;
        m_streak = 0; m_drained = 0; m_stall = 0;
    endtask

    function automatic logic [9:0] model_out(input in_t x);
        bit lu;
        lu = x.mr && x.rw && ((x.rs_u && x.rs == x.rd) || (x.rt_u && x.rt == x.rd));
        if (m_halted)   return {8'b0, 1'b1, m_err};
        if (m_in_wait)  return P_FRZ;
        if (m_draining) return x.busy ? P_FRZ : P_DRN;
        if (x.busy)     return P_FRZ;
        if (x.halt)     return P_DRN;
        if (x.redir)    return P_RDR;
        if (lu)         return P_LU;
        return P_RUN;
    endfunction

    task automatic model_step(input in_t x, input logic [9:0] o);
        if (!m_halted && !m_draining && !o[9] && m_stall < (2**CNT_W - 1)) m_stall++;
        if (m_halted) begin
        end else if (m_in_wait) begin
            if (!x.busy) begin
                m_in_wait = 0;
                m_streak  = 0;
            end else begin
                m_streak++;
                if (m_streak > MAX_WAIT) begin
                    m_err = 1; m_halted = 1; m_in_wait = 0;
                end
            end
        end else if (m_draining) begin
            if (!x.busy) begin
                m_drained++;
                if (m_drained > DRAIN_CYCLES) begin
                    m_halted = 1; m_draining = 0;
                end
            end
        end else if (x.busy) begin
            m_in_wait = 1; m_streak = 1;
        end else if (x.halt) begin
            m_draining = 1; m_drained = 1;
        end
    endtask

    // ---------------- helpers ----------------
    function automatic in_t mk(input int rs, input int rt, input bit rsu, input bit rtu,
                               input int rd, input bit rw, input bit mr,
                               input bit redir, input bit halt, input bit busy);
        in_t x;
        x.rs = 3'(rs); x.rt = 3'(rt); x.rs_u = rsu; x.rt_u = rtu; x.rd = 3'(rd);
        x.rw = rw; x.mr = mr; x.redir = redir; x.halt = halt; x.busy = busy;
        return x;
    endfunction

    task automatic apply(input in_t x);
        bus.ID_rs_addr   = x.rs;
        bus.ID_rt_addr   = x.rt;
        bus.ID_rs_used   = x.rs_u;
        bus.ID_rt_used   = x.rt_u;
        bus.EX_rd_addr   = x.rd;
        bus.EX_reg_write = x.rw;
        bus.EX_mem_read  = x.mr;
        bus.MEM_redirect = x.redir;
        bus.MEM_halt     = x.halt;
        bus.dmem_busy    = x.busy;
    endtask

    function automatic logic [9:0] pack_out();
        return {bus.pc_en, bus.if_id_en, bus.id_ex_en, bus.ex_mem_en, bus.mem_wb_en,
                bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_flush, bus.halted, bus.err};
    endfunction

    task automatic check(input string nm, input logic [9:0] act, input logic [9:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b expected=%b (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic check_cnt(input string nm);
`ifdef PIPE_HAZARD_STALL_CNT_EN
        checks++;
        if (stall_cnt !== CNT_W'(m_stall)) begin
            failures++;
            $display("FAIL %s stall_cnt actual=%0d expected=%0d", nm, stall_cnt, m_stall);
        end
`else
        if (nm.len() < 0) $display("%s", nm);
`endif
    endtask

    // One clock cycle: drive at posedge+1, compare at posedge+3, then advance
    task automatic drive_cycle(input in_t x, input bit use_tab, input logic [9:0] tab_exp,
                               input string nm);
        logic [9:0] mexp;
        apply(x);
        #2;
        mexp = model_out(x);
        check(nm, pack_out(), use_tab ? tab_exp : mexp);
        check_cnt(nm);
        @(posedge clk);
        model_step(x, mexp);
        #1;
    endtask

    task automatic do_reset();
        apply(mk(0,0,0,0,0,0,0,0,0,0));
        rst_n = 1'b0;
        model_reset();
        #3;
        check("reset_outputs", pack_out(), P_FRZ);
        check_cnt("reset_cnt");
        @(posedge clk);
        @(posedge clk);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    vec_t tab[$];

    task automatic add(input in_t x, input logic [9:0] e, input string nm);
        vec_t v;
        v.i = x; v.exp = e; v.name = nm;
        tab.push_back(v);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        in_t idle, busy, x;
        int  hcnt;
        checks = 0; failures = 0;
        rst_n  = 1'b0;
        idle = mk(0,0,0,0,0,0,0,0,0,0);
        busy = mk(0,0,0,0,0,0,0,0,0,1);

        add(idle,                          P_RUN, "idle_run");
        add(mk(3,5,1,0,3,1,1,0,0,0),       P_LU,  "load_use_rs");
        add(idle,                          P_RUN, "load_use_one_cycle");
        add(mk(3,5,0,0,3,1,1,0,0,0),       P_RUN, "load_use_rs_unused");
        add(mk(4,0,0,1,0,1,1,0,0,0),       P_LU,  "load_use_r0_rt");
        add(mk(3,3,1,1,3,0,1,0,0,0),       P_RUN, "load_no_regwrite");
        add(mk(3,3,1,1,3,1,0,0,0,0),       P_RUN, "alu_not_load");
        add(mk(2,6,1,1,3,1,1,0,0,0),       P_RUN, "load_no_match");
        add(mk(3,5,1,0,3,1,1,1,0,0),       P_RDR, "redirect_and_load_use");
        for (int k = 0; k < 4; k++) add(busy, P_FRZ, "mem_wait_busy");
        add(idle,                          P_FRZ, "mem_wait_release");
        add(idle,                          P_RUN, "mem_wait_resume");
        add(mk(0,0,0,0,0,0,0,0,1,0),       P_DRN, "halt_enter");
        add(mk(0,0,0,0,0,0,0,1,0,0),       P_DRN, "drain_redirect_ignored");
        add(busy,                          P_FRZ, "drain_busy_frozen");
        add(idle,                          P_DRN, "drain_last");
        add(mk(0,0,0,0,0,0,0,1,0,0),       P_HLT, "halted_redirect");
        add(mk(3,5,1,0,3,1,1,0,1,1),       P_HLT, "halted_ignores_inputs");

        do_reset();
        foreach (tab[i]) drive_cycle(tab[i].i, 1'b1, tab[i].exp, tab[i].name);

        // Memory timeout: err/halted rise on the 16th edge after entry
        do_reset();
        for (int j = 0; j <= MAX_WAIT + 3; j++)
            drive_cycle(busy, 1'b1, (j <= MAX_WAIT) ? P_FRZ : P_ERR, "timeout");
        for (int j = 0; j < 3; j++) drive_cycle(mk(1,1,1,1,1,1,1,1,0,0), 1'b1, P_ERR, "err_sticky");

        // Reset asserted mid-drain takes effect without a clock edge
        do_reset();
        drive_cycle(mk(0,0,0,0,0,0,0,0,1,0), 1'b1, P_DRN, "halt_before_reset");
        drive_cycle(idle, 1'b1, P_DRN, "drain_before_reset");
        #2 rst_n = 1'b0;
        model_reset();
        #1;
        check("async_reset_mid_drain", pack_out(), P_FRZ);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk);
        #1;
        drive_cycle(idle, 1'b1, P_RUN, "run_after_reset");

        // Random stimulus against the model
        hcnt = 0;
        for (int n = 0; n < 900; n++) begin
            bit heavy;
            heavy   = ((n / 60) % 4) == 3;
            x.rs    = 3'($urandom_range(0, 3));
            x.rt    = 3'($urandom_range(0, 3));
            x.rd    = 3'($urandom_range(0, 3));
            x.rs_u  = 1'($urandom_range(0, 1));
            x.rt_u  = 1'($urandom_range(0, 1));
            x.rw    = ($urandom_range(0, 3) != 0);
            x.mr    = ($urandom_range(0, 1) != 0);
            x.redir = ($urandom_range(0, 4) == 0);
            x.halt  = ($urandom_range(0, 29) == 0);
            x.busy  = heavy ? ($urandom_range(0, 19) != 0) : ($urandom_range(0, 5) == 0);
            drive_cycle(x, 1'b0, P_FRZ, "random");
            if (m_halted) hcnt++;
            if (hcnt > 3) begin
                do_reset();
                hcnt = 0;
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
